digit_counter: RTL and testbench

Upstream stage of the seven-segment display path: turns raw push-buttons and a free-running clock into a 0–7 digit value that the segment decoder converts to active-low segment patterns. It synchronises and debounces three buttons, keeps a run/pause flag and a count direction, and steps a 3-bit count either manually or on a prescaled tick. `count` is presented as a 4-bit bus whose MSB is always 0, so the decoder never sees codes 8–15.

---
 rtl/digit_counter_if.sv | 30 +++
 rtl/digit_counter.sv | 165 ++++++++++++++++
 tb/tb_digit_counter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/digit_counter_if.sv
// -----------------------------------------------------------------------------
// digit_counter_if
// Bundles the raw push-button inputs and the registered status outputs of the
// digit counter.
//   btn_up / btn_down / btn_run : raw asynchronous active-high buttons
//   count[3:0]                  : current digit 0..7, bit 3 always 0
//   tick                        : one-cycle prescaler pulse
//   running                     : run/pause flag
//   dir_up                      : auto-step direction (1 = increment)
// Modports: slave = the counter itself, master = whoever drives the buttons.
// -----------------------------------------------------------------------------
interface digit_counter_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_run;
  logic [3:0] count;
  logic       tick;
  logic       running;
  logic       dir_up;

  modport slave (
    input  btn_up, btn_down, btn_run,
    output count, tick, running, dir_up
  );

  modport master (
    output btn_up, btn_down, btn_run,
    input  count, tick, running, dir_up
  );
endinterface

// File: rtl/digit_counter.sv
// -----------------------------------------------------------------------------
// digit_counter
// Synchronises and debounces three raw buttons, keeps a run/pause flag and a
// count direction, and steps a 3-bit digit manually or on a prescaled tick.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : digit_counter_if.slave (buttons in, count/tick/running/dir_up out)
// Parameters:
//   CLK_HZ / TICK_HZ : prescaler divide ratio DIV = CLK_HZ / TICK_HZ (>= 2)
//   DEB_CYCLES       : stable synced cycles needed to accept a level (>= 2)
// -----------------------------------------------------------------------------
module digit_counter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  digit_counter_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  // Button index order: 0 = up, 1 = down, 2 = run
  logic [2:0]    w_btn_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [DW-1:0] r_deb_cnt [0:2];
  logic [2:0]    r_deb_lvl;
  logic [2:0]    r_deb_dly;
  logic [2:0]    r_press;

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic [2:0]    r_count;
  logic          r_dir_up;
  logic          r_running;

  logic          w_up_p;
  logic          w_dn_p;
  logic          w_run_p;
  logic [2:0]    w_count_nxt;
  logic          w_dir_nxt;

  assign w_btn_raw = {bus.btn_run, bus.btn_down, bus.btn_up};

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: the level flips only after DEB_CYCLES consecutive
  // disagreeing synced samples; any agreement restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_deb_cnt[i] <= {DW{1'b0}};
      end
      r_deb_lvl <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb_lvl[i]) begin
          r_deb_cnt[i] <= {DW{1'b0}};
        end else if (r_deb_cnt[i] == DEB_MAX) begin
          r_deb_lvl[i] <= ~r_deb_lvl[i];
          r_deb_cnt[i] <= {DW{1'b0}};
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising-edge detector on the debounced levels; releases give no pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_dly <= 3'b000;
      r_press   <= 3'b000;
    end else begin
      r_deb_dly <= r_deb_lvl;
      r_press   <= r_deb_lvl & ~r_deb_dly;
    end
  end

  // Prescaler: counts only while running, so a resume restarts a full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= {PW{1'b0}};
      r_tick  <= 1'b0;
    end else if (r_running) begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= {PW{1'b0}};
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end
    end else begin
      r_presc <= {PW{1'b0}};
      r_tick  <= 1'b0;
    end
  end

  assign w_up_p  = r_press[0];
  assign w_dn_p  = r_press[1];
  assign w_run_p = r_press[2];

  // Step selection: a manual press always wins over the tick, and a
  // simultaneous up+down press cancels everything including the tick
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir_up;
    if (w_up_p && w_dn_p) begin
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir_up;
    end else if (w_up_p) begin
      w_count_nxt = r_count + 3'd1;
      w_dir_nxt   = 1'b1;
    end else if (w_dn_p) begin
      w_count_nxt = r_count - 3'd1;
      w_dir_nxt   = 1'b0;
    end else if (r_tick) begin
      w_count_nxt = r_dir_up ? (r_count + 3'd1) : (r_count - 3'd1);
      w_dir_nxt   = r_dir_up;
    end else begin
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir_up;
    end
  end

  // Digit, direction and run-flag registers (3-bit count wraps modulo 8)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= 3'd0;
      r_dir_up  <= 1'b1;
      r_running <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_dir_up <= w_dir_nxt;
      if (w_run_p) begin
        r_running <= ~r_running;
      end else begin
        r_running <= r_running;
      end
    end
  end

  assign bus.count   = {1'b0, r_count};
  assign bus.tick    = r_tick;
  assign bus.running = r_running;
  assign bus.dir_up  = r_dir_up;

endmodule

// File: tb/tb_digit_counter.sv
// -----------------------------------------------------------------------------
// tb_digit_counter
// Directed bench for digit_counter with DEB_CYCLES=4, CLK_HZ=10, TICK_HZ=1.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_digit_counter;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  digit_counter_if bus ();

  digit_counter #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .DEB_CYCLES (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = up, 1 = down, 2 = run, 3 = up+down together
  task automatic press_btn(input int which, input int hold);
    case (which)
      0:       bus.btn_up   = 1'b1;
      1:       bus.btn_down = 1'b1;
      2:       bus.btn_run  = 1'b1;
      default: begin bus.btn_up = 1'b1; bus.btn_down = 1'b1; end
    endcase
    step_n(hold);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_run  = 1'b0;
    step_n(12);
  endtask

  initial begin
    int exp_cnt;
    int exp_tick;
    int exp_run;
    vec_cnt      = 0;
    err_cnt      = 0;
    rst          = 1'b1;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_run  = 1'b0;

    // Reset state
    step_n(2);
    check_val("rst_count",   int'(bus.count),   0);
    check_val("rst_running", int'(bus.running), 0);
    check_val("rst_dir_up",  int'(bus.dir_up),  1);
    check_val("rst_tick",    int'(bus.tick),    0);
    #3 rst = 1'b0;
    step_n(2);

    // Eight clean up presses: update lands exactly on edge 8
    for (int i = 0; i < 8; i++) begin
      bus.btn_up = 1'b1;
      step_n(7);
      check_val("up_edge7", int'(bus.count), i);
      step_n(1);
      check_val("up_edge8", int'(bus.count), (i + 1) % 8);
      check_val("up_dir",   int'(bus.dir_up), 1);
      bus.btn_up = 1'b0;
      step_n(10);
    end

    // Down from 0 wraps to 7
    press_btn(1, 10);
    check_val("down_wrap", int'(bus.count),  7);
    check_val("down_dir",  int'(bus.dir_up), 0);

    // 3-cycle glitch: ignored
    press_btn(0, 3);
    check_val("glitch_count", int'(bus.count),  7);
    check_val("glitch_dir",   int'(bus.dir_up), 0);

    // Long hold: exactly one increment
    press_btn(0, 50);
    check_val("hold_count", int'(bus.count),  0);
    check_val("hold_dir",   int'(bus.dir_up), 1);

    // Bounce 1,0,1,1,1,1 then held: one increment after the stable run
    bus.btn_up = 1'b1; step_n(1);
    bus.btn_up = 1'b0; step_n(1);
    bus.btn_up = 1'b1; step_n(4);
    check_val("bounce_early", int'(bus.count), 0);
    step_n(6);
    bus.btn_up = 1'b0;
    step_n(12);
    check_val("bounce_count", int'(bus.count), 1);

    // Auto mode: run press, ticks at 18 and 28, count one cycle later
    bus.btn_run = 1'b1;
    for (int e = 1; e <= 29; e++) begin
      step_n(1);
      if (e == 12) bus.btn_run = 1'b0;
      exp_tick = (e == 18 || e == 28) ? 1 : 0;
      exp_cnt  = (e < 19) ? 1 : ((e < 29) ? 2 : 3);
      exp_run  = (e >= 8) ? 1 : 0;
      check_val("auto_tick",    int'(bus.tick),    exp_tick);
      check_val("auto_count",   int'(bus.count),   exp_cnt);
      check_val("auto_running", int'(bus.running), exp_run);
    end

    // Pause: no further ticks
    bus.btn_run = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      step_n(1);
      if (e == 12) bus.btn_run = 1'b0;
      exp_run = (e < 8) ? 1 : 0;
      check_val("pause_tick",    int'(bus.tick),    0);
      check_val("pause_count",   int'(bus.count),   3);
      check_val("pause_running", int'(bus.running), exp_run);
    end

    // Resume, up pulse colliding with the tick at 28, then pause again
    bus.btn_run = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      step_n(1);
      if (e == 12) bus.btn_run = 1'b0;
      if (e == 21) bus.btn_up  = 1'b1;
      if (e == 35) begin
        bus.btn_up  = 1'b0;
        bus.btn_run = 1'b1;
      end
      if (e == 47) bus.btn_run = 1'b0;
      exp_tick = (e == 18 || e == 28 || e == 38) ? 1 : 0;
      exp_cnt  = (e < 19) ? 3 : ((e < 29) ? 4 : ((e < 39) ? 5 : 6));
      exp_run  = (e >= 8 && e < 43) ? 1 : 0;
      check_val("resume_tick",    int'(bus.tick),    exp_tick);
      check_val("resume_count",   int'(bus.count),   exp_cnt);
      check_val("resume_running", int'(bus.running), exp_run);
    end

    // Up and down together: nothing changes
    press_btn(3, 10);
    check_val("both_count", int'(bus.count),  6);
    check_val("both_dir",   int'(bus.dir_up), 1);

    // Reach count=5 running, then reset with btn_up held
    press_btn(1, 10);
    check_val("pre_rst_count", int'(bus.count), 5);
    bus.btn_run = 1'b1;
    step_n(8);
    check_val("pre_rst_running", int'(bus.running), 1);
    bus.btn_run = 1'b0;
    bus.btn_up  = 1'b1;
    step_n(2);
    #3 rst = 1'b1;
    #1;
    check_val("async_rst_count",   int'(bus.count),   0);
    check_val("async_rst_running", int'(bus.running), 0);
    check_val("async_rst_dir_up",  int'(bus.dir_up),  1);
    check_val("async_rst_tick",    int'(bus.tick),    0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    step_n(7);
    check_val("post_rst_edge7", int'(bus.count), 0);
    step_n(1);
    check_val("post_rst_edge8", int'(bus.count), 1);
    step_n(20);
    check_val("post_rst_hold",    int'(bus.count),   1);
    check_val("post_rst_running", int'(bus.running), 0);
    check_val("post_rst_dir",     int'(bus.dir_up),  1);
    bus.btn_up = 1'b0;
    step_n(12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
